// File: rtl/spi_pkg.sv
// Shared SPI register-write frame definitions: frame geometry, write flag,
// controller state encoding and a frame-packing helper. The same constants
// serve the peripheral side of the link.
package spi_pkg;

  localparam int FRAME_W    = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int BIT_CNT_W  = 5;

  localparam logic                 WRITE_FLAG = 1'b1;
  // Value of the bit counter while the final (16th) high phase is running.
  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = 5'd15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } spi_state_e;

  // Pack a write request into the on-wire frame, MSB transmitted first.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {WRITE_FLAG, addr, data};
  endfunction

  // States during which chip select is asserted (ncs low).
  function automatic logic frame_active(input spi_state_e st);
    return (st == SETUP) || (st == SHIFT_HI) || (st == SHIFT_LO) || (st == HOLD);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase-duration counter. The owner loads (duration - 1) whenever its state
// changes; phase_end is high during the last cycle of the current phase.
module spi_tick_gen #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_end
);

  logic [CNT_W-1:0] cnt_r;

  // Count down from the loaded value and park at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign phase_end = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/spi_controller_tx.sv
// SPI mode-0 write-only initiator. Accepts one {addr, data} request at a time
// and emits a 16-bit frame {1, addr, data} MSB first on ncs/sclk/copi.
// All interface outputs are registered from the next-state decode so they
// change on the same edge as the state register.
module spi_controller_tx
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ncs,
  output logic              copi
);

  localparam int MAX_DUR = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] HP_LOAD  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("spi_controller_tx: HALF_PERIOD must be >= 2");
  end
  if (GAP_CYCLES < 2) begin : g_bad_gap_cycles
    $error("spi_controller_tx: GAP_CYCLES must be >= 2");
  end

  spi_state_e           state_r;
  spi_state_e           state_next_s;
  logic [FRAME_W-1:0]   shift_r;
  logic [FRAME_W-1:0]   shift_next_s;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic [BIT_CNT_W-1:0] bit_cnt_next_s;
  logic                 load_s;
  logic [CNT_W-1:0]     load_val_s;
  logic                 phase_end_s;

  spi_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .phase_end(phase_end_s)
  );

  // Next-state, frame shift and bit-count decode.
  always_comb begin
    state_next_s   = state_r;
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_next_s   = SETUP;
          shift_next_s   = build_frame(req_addr, req_data);
          bit_cnt_next_s = {BIT_CNT_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        if (phase_end_s) begin
          state_next_s = SHIFT_HI;
        end else begin
          state_next_s = SETUP;
        end
      end
      SHIFT_HI: begin
        if (phase_end_s) begin
          bit_cnt_next_s = bit_cnt_r + 5'd1;
          if (bit_cnt_r == LAST_BIT) begin
            // Last bit stays on copi through HOLD, so no shift here.
            state_next_s = HOLD;
          end else begin
            // Falling sclk: present the next bit.
            state_next_s = SHIFT_LO;
            shift_next_s = {shift_r[FRAME_W-2:0], 1'b0};
          end
        end else begin
          state_next_s = SHIFT_HI;
        end
      end
      SHIFT_LO: begin
        if (phase_end_s) begin
          state_next_s = SHIFT_HI;
        end else begin
          state_next_s = SHIFT_LO;
        end
      end
      HOLD: begin
        if (phase_end_s) begin
          state_next_s = GAP;
        end else begin
          state_next_s = HOLD;
        end
      end
      GAP: begin
        if (phase_end_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GAP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Reload the phase counter on every state change with the new phase length.
  always_comb begin
    load_s = (state_next_s != state_r);
    if (state_next_s == GAP) begin
      load_val_s = GAP_LOAD;
    end else begin
      load_val_s = HP_LOAD;
    end
  end

  // State, datapath and registered interface outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= {FRAME_W{1'b0}};
      bit_cnt_r <= {BIT_CNT_W{1'b0}};
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      shift_r   <= shift_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      sclk      <= (state_next_s == SHIFT_HI);
      ncs       <= !frame_active(state_next_s);
      copi      <= frame_active(state_next_s) ? shift_next_s[FRAME_W-1] : 1'b0;
      busy      <= (state_next_s != IDLE);
      done      <= (state_r == HOLD) && (state_next_s == GAP);
      req_ready <= (state_next_s == IDLE);
    end
  end

endmodule
